// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, registered inter-chunk carry.
// Optional: define ADDSUB_SEQ_ACCUM_EN to add acc_i, which takes operand A from the current res_o.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
`ifdef ADDSUB_SEQ_ACCUM_EN
    input  logic             acc_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             cb_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             op_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] a_sel;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Overflow compares against the already-inverted B operand, so it covers add and sub alike.
    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] x,
                                        input logic signed [WIDTH-1:0] y,
                                        input logic signed [WIDTH-1:0] s);
        signed_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

`ifdef ADDSUB_SEQ_ACCUM_EN
    assign a_sel = acc_i ? res_o : a_i;
`else
    assign a_sel = a_i;
`endif

    always_comb begin
        a_chunk   = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_chunk   = b_q[int'(idx_q)*CHUNK +: CHUNK];
        chunk_sum = chunk_add(a_chunk, b_chunk, carry_q);
        sum_next  = sum_q;
        sum_next[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            res_o   <= '0;
            cb_o    <= 1'b0;
            ovf_o   <= 1'b0;
            zero_o  <= 1'b0;
            neg_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_sel;
                        b_q     <= b_i ^ {WIDTH{sub_i}};
                        op_q    <= sub_i;
                        carry_q <= sub_i;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        busy_o  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_next;
                    carry_q <= chunk_sum[CHUNK];
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        res_o  <= sum_next;
                        cb_o   <= chunk_sum[CHUNK] ^ op_q;
                        ovf_o  <= signed_ovf(a_q, b_q, sum_next);
                        zero_o <= (sum_next == '0);
                        neg_o  <= sum_next[WIDTH-1];
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
